roce_responder_ack_gen: RTL and testbench
=========================================

ROCE_RESPONDER_ACK_GEN -- requirements
Module: roce_responder_ack_gen

Interface
REQ-001 SHALL have no parameters; PSN, MSN and QPN are fixed at 24 bits.
REQ-002 SHALL have port clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port rst_qp, input, 1 bit: synchronous QP re-init; loads qp_init_* values.
REQ-005 SHALL have ports qp_init_loc_qpn, qp_init_rem_qpn and qp_init_exp_psn, inputs, 24 bits each: local QPN, remote QPN and first expected PSN.
REQ-006 SHALL have the RX BTH sink ports s_roce_rx_bth_valid in 1, s_roce_rx_bth_ready out 1, s_roce_rx_bth_op_code in 8, s_roce_rx_bth_p_key in 16, s_roce_rx_bth_psn in 24, s_roce_rx_bth_dest_qp in 24, s_roce_rx_bth_ack_req in 1.
REQ-007 SHALL have the TX BTH source ports m_roce_tx_bth_valid out 1, m_roce_tx_bth_ready in 1, m_roce_tx_bth_op_code out 8, m_roce_tx_bth_p_key out 16, m_roce_tx_bth_psn out 24, m_roce_tx_bth_dest_qp out 24, m_roce_tx_bth_ack_req out 1.
REQ-008 SHALL have the TX AETH ports m_roce_tx_aeth_valid out 1, m_roce_tx_aeth_syndrome out 8, m_roce_tx_aeth_msn out 24.
REQ-009 SHALL have the status outputs expected_psn out 24, current_msn out 24, nak_outstanding out 1.

Function
REQ-010 SHALL accept a BTH only on valid&&ready; BTHs whose dest_qp differs from the local QPN, or whose opcode is outside 0x06-0x0B, SHALL be consumed with no state change.
REQ-011 SHALL classify d=(psn-epsn) mod 2^24: d=0 in-order; d in 0x800000..0xFFFFFF duplicate; d in 1..0x7FFFFF sequence error.
REQ-012 On in-order: epsn SHALL become epsn+1 mod 2^24; MSN SHALL become MSN+1 mod 2^24 for opcodes 0x08, 0x09, 0x0A, 0x0B.
REQ-013 SHALL generate an ACK for an in-order packet with ack_req=1 or opcode in {0x08,0x09,0x0A,0x0B}; otherwise none.
REQ-014 The ACK SHALL carry op_code 0x11, psn = received PSN, dest_qp = remote QPN, p_key = received p_key, ack_req 0, syndrome 0x1F, msn = updated MSN.
REQ-015 On a sequence error outside NAK_WAIT, SHALL emit a NAK with syndrome 0x60, psn = epsn, msn = current MSN, and SHALL set nak_outstanding.
REQ-016 SHALL implement the FSM IDLE -> SEND_ACK | SEND_NAK; SEND_ACK -> IDLE on ready; SEND_NAK -> NAK_WAIT on ready; NAK_WAIT -> SEND_ACK or IDLE on an in-order packet.
REQ-017 In NAK_WAIT, sequence-error and duplicate packets SHALL be dropped silently; an in-order packet SHALL clear nak_outstanding and be processed per REQ-012/013.
REQ-018 s_roce_rx_bth_ready SHALL be 1 only in IDLE and NAK_WAIT.
REQ-019 m_roce_tx_bth_valid and m_roce_tx_aeth_valid SHALL assert together one cycle after acceptance and hold, with stable data, until m_roce_tx_bth_ready.
REQ-020 rst_qp SHALL take priority over any simultaneous event, drop a pending output, clear nak_outstanding and go to IDLE with MSN=0.
REQ-021 PSN 0xFFFFFF in-order SHALL wrap epsn to 0x000000.

Reset
REQ-022 rst_n low SHALL force IDLE, epsn/MSN/QPNs to 0, every valid output and nak_outstanding to 0, all data outputs to 0, and ready to 0 while asserted.

Configuration
REQ-023 With ROCE_DUP_ACK_EN defined, a duplicate outside NAK_WAIT SHALL emit an ACK with psn=epsn-1 mod 2^24, syndrome 0x1F, msn=current MSN, and no state change; without it, duplicates SHALL be dropped silently.

Structure
REQ-024 Opcode constants, syndromes 0x1F/0x60 and FSM state encodings SHALL live in shared package roce_pkg.
REQ-025 PSN classification SHALL be the combinational sub-module roce_psn_compare (inputs psn and epsn, outputs in_order, duplicate, seq_err).

Verification
REQ-026 After rst_qp with exp_psn=0x000010 and loc_qpn=0x11: WRITE_FIRST psn 0x10 with ack_req=0, then WRITE_LAST psn 0x11 -> one ACK psn 0x11, msn 1, epsn 0x12.
REQ-027 epsn 0x20, WRITE_MIDDLE psn 0x22 -> NAK syndrome 0x60 psn 0x20; psn 0x23 then dropped; psn 0x20 WRITE_ONLY -> ACK, nak_outstanding 0.
REQ-028 epsn 0xFFFFFF, WRITE_ONLY psn 0xFFFFFF -> ACK psn 0xFFFFFF, epsn 0x000000.
REQ-029 With ROCE_DUP_ACK_EN, epsn 0x30, psn 0x2E -> ACK psn 0x2F; without it, no output.
REQ-030 Hold m_roce_tx_bth_ready=0 for 5 cycles -> ACK fields stable, s_roce_rx_bth_ready=0; rst_qp in cycle 3 -> valid drops next cycle.

Source files
------------

// File: rtl/roce_pkg.sv
// Shared constants for the RoCE responder ACK path: BTH opcodes, AETH
// syndromes and the ACK-generator FSM encoding.
package roce_pkg;

  localparam logic [7:0] OP_RC_WRITE_FIRST    = 8'h06;
  localparam logic [7:0] OP_RC_WRITE_MIDDLE   = 8'h07;
  localparam logic [7:0] OP_RC_WRITE_LAST     = 8'h08;
  localparam logic [7:0] OP_RC_WRITE_LAST_IMM = 8'h09;
  localparam logic [7:0] OP_RC_WRITE_ONLY     = 8'h0A;
  localparam logic [7:0] OP_RC_WRITE_ONLY_IMM = 8'h0B;
  localparam logic [7:0] OP_RC_ACK            = 8'h11;

  localparam logic [7:0] SYN_ACK     = 8'h1F;
  localparam logic [7:0] SYN_NAK_SEQ = 8'h60;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND_ACK = 2'd1,
    ST_SEND_NAK = 2'd2,
    ST_NAK_WAIT = 2'd3
  } ack_state_e;

  function automatic logic is_write_op(input logic [7:0] op);
    return (op >= OP_RC_WRITE_FIRST) && (op <= OP_RC_WRITE_ONLY_IMM);
  endfunction

  // Opcodes that close a message: they bump the MSN and always get an ACK.
  function automatic logic is_msg_end(input logic [7:0] op);
    return (op >= OP_RC_WRITE_LAST) && (op <= OP_RC_WRITE_ONLY_IMM);
  endfunction

endpackage

// File: rtl/roce_psn_compare.sv
// Combinational PSN classifier: distance psn-epsn modulo 2^24, upper half
// of the window is treated as already-seen.
module roce_psn_compare (
  input  logic [23:0] psn,
  input  logic [23:0] epsn,
  output logic        in_order,
  output logic        duplicate,
  output logic        seq_err
);
  logic [23:0] d;

  assign d         = psn - epsn;
  assign in_order  = (d == 24'd0);
  assign duplicate = d[23];
  assign seq_err   = (d != 24'd0) && !d[23];
endmodule

// File: rtl/roce_responder_ack_gen.sv
// RC responder ACK/NAK generator for RDMA WRITE traffic.
// Optional ROCE_DUP_ACK_EN: re-ACK duplicates with psn = epsn-1.
module roce_responder_ack_gen
  import roce_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rst_qp,
  input  logic [23:0] qp_init_loc_qpn,
  input  logic [23:0] qp_init_rem_qpn,
  input  logic [23:0] qp_init_exp_psn,
  input  logic        s_roce_rx_bth_valid,
  output logic        s_roce_rx_bth_ready,
  input  logic [7:0]  s_roce_rx_bth_op_code,
  input  logic [15:0] s_roce_rx_bth_p_key,
  input  logic [23:0] s_roce_rx_bth_psn,
  input  logic [23:0] s_roce_rx_bth_dest_qp,
  input  logic        s_roce_rx_bth_ack_req,
  output logic        m_roce_tx_bth_valid,
  input  logic        m_roce_tx_bth_ready,
  output logic [7:0]  m_roce_tx_bth_op_code,
  output logic [15:0] m_roce_tx_bth_p_key,
  output logic [23:0] m_roce_tx_bth_psn,
  output logic [23:0] m_roce_tx_bth_dest_qp,
  output logic        m_roce_tx_bth_ack_req,
  output logic        m_roce_tx_aeth_valid,
  output logic [7:0]  m_roce_tx_aeth_syndrome,
  output logic [23:0] m_roce_tx_aeth_msn,
  output logic [23:0] expected_psn,
  output logic [23:0] current_msn,
  output logic        nak_outstanding
);
  ack_state_e  state_q;
  logic        rdy_q, vld_q, nak_q;
  logic [23:0] epsn_q, msn_q, loc_qpn_q, rem_qpn_q;
  logic [7:0]  op_q, syn_q;
  logic [15:0] pkey_q;
  logic [23:0] psn_q, msn_out_q;

  logic        in_order, duplicate, seq_err;
  logic        acc, pkt_ok, msg_end;
  logic [23:0] msn_d;

  roce_psn_compare u_cmp (
    .psn       (s_roce_rx_bth_psn),
    .epsn      (epsn_q),
    .in_order  (in_order),
    .duplicate (duplicate),
    .seq_err   (seq_err)
  );

  assign acc     = s_roce_rx_bth_valid && rdy_q;
  assign pkt_ok  = (s_roce_rx_bth_dest_qp == loc_qpn_q) && is_write_op(s_roce_rx_bth_op_code);
  assign msg_end = is_msg_end(s_roce_rx_bth_op_code);
  assign msn_d   = msg_end ? msn_q + 24'd1 : msn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rdy_q     <= 1'b0;
      vld_q     <= 1'b0;
      nak_q     <= 1'b0;
      epsn_q    <= '0;
      msn_q     <= '0;
      loc_qpn_q <= '0;
      rem_qpn_q <= '0;
      op_q      <= '0;
      syn_q     <= '0;
      pkey_q    <= '0;
      psn_q     <= '0;
      msn_out_q <= '0;
    end else if (rst_qp) begin
      // QP re-init wins over any handshake in the same cycle.
      state_q   <= ST_IDLE;
      rdy_q     <= 1'b1;
      vld_q     <= 1'b0;
      nak_q     <= 1'b0;
      epsn_q    <= qp_init_exp_psn;
      msn_q     <= '0;
      loc_qpn_q <= qp_init_loc_qpn;
      rem_qpn_q <= qp_init_rem_qpn;
      op_q      <= '0;
      syn_q     <= '0;
      pkey_q    <= '0;
      psn_q     <= '0;
      msn_out_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_NAK_WAIT: begin
          if (acc && pkt_ok) begin
            if (in_order) begin
              epsn_q <= epsn_q + 24'd1;
              msn_q  <= msn_d;
              nak_q  <= 1'b0;
              if (s_roce_rx_bth_ack_req || msg_end) begin
                state_q   <= ST_SEND_ACK;
                rdy_q     <= 1'b0;
                vld_q     <= 1'b1;
                op_q      <= OP_RC_ACK;
                syn_q     <= SYN_ACK;
                pkey_q    <= s_roce_rx_bth_p_key;
                psn_q     <= s_roce_rx_bth_psn;
                msn_out_q <= msn_d;
              end else begin
                state_q <= ST_IDLE;
              end
            end else if (seq_err && state_q == ST_IDLE) begin
              state_q   <= ST_SEND_NAK;
              rdy_q     <= 1'b0;
              vld_q     <= 1'b1;
              nak_q     <= 1'b1;
              op_q      <= OP_RC_ACK;
              syn_q     <= SYN_NAK_SEQ;
              pkey_q    <= s_roce_rx_bth_p_key;
              psn_q     <= epsn_q;
              msn_out_q <= msn_q;
            end
`ifdef ROCE_DUP_ACK_EN
            else if (duplicate && state_q == ST_IDLE) begin
              state_q   <= ST_SEND_ACK;
              rdy_q     <= 1'b0;
              vld_q     <= 1'b1;
              op_q      <= OP_RC_ACK;
              syn_q     <= SYN_ACK;
              pkey_q    <= s_roce_rx_bth_p_key;
              psn_q     <= epsn_q - 24'd1;
              msn_out_q <= msn_q;
            end
`endif
          end
        end
        ST_SEND_ACK: if (m_roce_tx_bth_ready) begin
          state_q <= ST_IDLE;
          rdy_q   <= 1'b1;
          vld_q   <= 1'b0;
        end
        ST_SEND_NAK: if (m_roce_tx_bth_ready) begin
          state_q <= ST_NAK_WAIT;
          rdy_q   <= 1'b1;
          vld_q   <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifndef ROCE_DUP_ACK_EN
  logic unused_dup;
  assign unused_dup = duplicate;
`endif

  assign s_roce_rx_bth_ready     = rdy_q;
  assign m_roce_tx_bth_valid     = vld_q;
  assign m_roce_tx_aeth_valid    = vld_q;
  assign m_roce_tx_bth_op_code   = op_q;
  assign m_roce_tx_bth_p_key     = pkey_q;
  assign m_roce_tx_bth_psn       = psn_q;
  assign m_roce_tx_bth_dest_qp   = vld_q ? rem_qpn_q : '0;
  assign m_roce_tx_bth_ack_req   = 1'b0;
  assign m_roce_tx_aeth_syndrome = syn_q;
  assign m_roce_tx_aeth_msn      = msn_out_q;
  assign expected_psn            = epsn_q;
  assign current_msn             = msn_q;
  assign nak_outstanding         = nak_q;
endmodule

// File: tb/tb_roce_responder_ack_gen.sv
// Directed bench for roce_responder_ack_gen; expectations hand-computed.
module tb_roce_responder_ack_gen;
  logic        clk = 1'b0;
  logic        rst_n, rst_qp;
  logic [23:0] init_loc, init_rem, init_epsn;
  logic        rx_valid, rx_ready, rx_ack_req;
  logic [7:0]  rx_op;
  logic [15:0] rx_pkey;
  logic [23:0] rx_psn, rx_dqp;
  logic        tx_valid, tx_ready, tx_ack_req, aeth_valid;
  logic [7:0]  tx_op, tx_syn;
  logic [15:0] tx_pkey;
  logic [23:0] tx_psn, tx_dqp, tx_msn;
  logic [23:0] epsn, msn;
  logic        nak;

  int n_chk = 0;
  int n_fail = 0;
  int tx_cnt = 0;

  always #5 clk = ~clk;

  roce_responder_ack_gen dut (
    .clk(clk), .rst_n(rst_n), .rst_qp(rst_qp),
    .qp_init_loc_qpn(init_loc), .qp_init_rem_qpn(init_rem), .qp_init_exp_psn(init_epsn),
    .s_roce_rx_bth_valid(rx_valid), .s_roce_rx_bth_ready(rx_ready),
    .s_roce_rx_bth_op_code(rx_op), .s_roce_rx_bth_p_key(rx_pkey),
    .s_roce_rx_bth_psn(rx_psn), .s_roce_rx_bth_dest_qp(rx_dqp),
    .s_roce_rx_bth_ack_req(rx_ack_req),
    .m_roce_tx_bth_valid(tx_valid), .m_roce_tx_bth_ready(tx_ready),
    .m_roce_tx_bth_op_code(tx_op), .m_roce_tx_bth_p_key(tx_pkey),
    .m_roce_tx_bth_psn(tx_psn), .m_roce_tx_bth_dest_qp(tx_dqp),
    .m_roce_tx_bth_ack_req(tx_ack_req),
    .m_roce_tx_aeth_valid(aeth_valid), .m_roce_tx_aeth_syndrome(tx_syn),
    .m_roce_tx_aeth_msn(tx_msn),
    .expected_psn(epsn), .current_msn(msn), .nak_outstanding(nak)
  );

  always @(posedge clk) if (tx_valid && tx_ready) tx_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic qp_init(input logic [23:0] e);
    @(negedge clk);
    init_loc = 24'h000011; init_rem = 24'h000022; init_epsn = e; rst_qp = 1'b1;
    @(negedge clk);
    rst_qp = 1'b0;
  endtask

  // Drives one BTH and returns #1 after the accepting edge.
  task automatic send(input logic [7:0] op, input logic [23:0] psn,
                      input logic ack, input logic [23:0] dqp);
    int n;
    @(negedge clk);
    rx_op = op; rx_psn = psn; rx_ack_req = ack; rx_dqp = dqp; rx_pkey = 16'hBEEF;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 20) begin @(negedge clk); n++; end
    n_chk++;
    if (!rx_ready) begin n_fail++; $display("FAIL send_timeout: rx_ready=%b required 1", rx_ready); end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic chk_none(input string nm, input logic [23:0] e_epsn, input logic [23:0] e_msn);
    @(negedge clk);
    n_chk++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL %s_valid: got %b required 0", nm, tx_valid); end
    n_chk++; if (epsn !== e_epsn) begin n_fail++; $display("FAIL %s_epsn: got %h required %h", nm, epsn, e_epsn); end
    n_chk++; if (msn !== e_msn) begin n_fail++; $display("FAIL %s_msn: got %h required %h", nm, msn, e_msn); end
  endtask

  task automatic chk_tx(input string nm, input logic [7:0] e_syn, input logic [23:0] e_psn,
                        input logic [23:0] e_msn);
    @(negedge clk);
    n_chk++; if ({tx_valid, aeth_valid} !== 2'b11) begin n_fail++; $display("FAIL %s_valid: got %b%b required 11", nm, tx_valid, aeth_valid); end
    n_chk++; if (tx_op !== 8'h11) begin n_fail++; $display("FAIL %s_op: got %h required 11", nm, tx_op); end
    n_chk++; if (tx_syn !== e_syn) begin n_fail++; $display("FAIL %s_syn: got %h required %h", nm, tx_syn, e_syn); end
    n_chk++; if (tx_psn !== e_psn) begin n_fail++; $display("FAIL %s_psn: got %h required %h", nm, tx_psn, e_psn); end
    n_chk++; if (tx_msn !== e_msn) begin n_fail++; $display("FAIL %s_msn: got %h required %h", nm, tx_msn, e_msn); end
    n_chk++; if (tx_dqp !== 24'h000022) begin n_fail++; $display("FAIL %s_dqp: got %h required 000022", nm, tx_dqp); end
    n_chk++; if (tx_pkey !== 16'hBEEF) begin n_fail++; $display("FAIL %s_pkey: got %h required beef", nm, tx_pkey); end
    n_chk++; if (tx_ack_req !== 1'b0) begin n_fail++; $display("FAIL %s_ackreq: got %b required 0", nm, tx_ack_req); end
    n_chk++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL %s_rxrdy: got %b required 0", nm, rx_ready); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rst_qp = 1'b0; rx_valid = 1'b0; tx_ready = 1'b1;
    rx_op = '0; rx_psn = '0; rx_dqp = '0; rx_pkey = '0; rx_ack_req = 1'b0;
    init_loc = '0; init_rem = '0; init_epsn = '0;
    repeat (3) @(negedge clk);
    n_chk++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rst_rxrdy: got %b required 0", rx_ready); end
    n_chk++; if ({tx_valid, aeth_valid, nak} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b required 000", {tx_valid, aeth_valid, nak}); end
    n_chk++; if ({epsn, msn} !== 48'h0) begin n_fail++; $display("FAIL rst_state: got %h required 0", {epsn, msn}); end
    n_chk++; if ({tx_op, tx_psn, tx_msn, tx_syn, tx_dqp, tx_pkey} !== 104'h0) begin n_fail++; $display("FAIL rst_data: got %h required 0", {tx_op, tx_psn, tx_msn, tx_syn, tx_dqp, tx_pkey}); end
    rst_n = 1'b1;
  endtask

  task automatic test_write_ack;
    int c0;
    qp_init(24'h000010);
    @(negedge clk);
    n_chk++; if (epsn !== 24'h000010 || msn !== 24'h0 || rx_ready !== 1'b1) begin n_fail++; $display("FAIL init: epsn %h msn %h rdy %b required 000010 000000 1", epsn, msn, rx_ready); end
    c0 = tx_cnt;
    send(8'h06, 24'h000010, 1'b0, 24'h000011);
    chk_none("wfirst", 24'h000011, 24'h0);
    send(8'h08, 24'h000011, 1'b0, 24'h000011);
    chk_tx("wlast", 8'h1F, 24'h000011, 24'h000001);
    @(negedge clk);
    n_chk++; if (epsn !== 24'h000012) begin n_fail++; $display("FAIL wlast_epsn: got %h required 000012", epsn); end
    n_chk++; if (tx_cnt - c0 !== 1) begin n_fail++; $display("FAIL wlast_count: got %0d required 1", tx_cnt - c0); end
  endtask

  task automatic test_nak;
    qp_init(24'h000020);
    send(8'h07, 24'h000022, 1'b0, 24'h000011);
    chk_tx("nak", 8'h60, 24'h000020, 24'h0);
    n_chk++; if (nak !== 1'b1) begin n_fail++; $display("FAIL nak_set: got %b required 1", nak); end
    send(8'h07, 24'h000023, 1'b0, 24'h000011);
    chk_none("nakdrop", 24'h000020, 24'h0);
    n_chk++; if (nak !== 1'b1) begin n_fail++; $display("FAIL nak_hold: got %b required 1", nak); end
    send(8'h0A, 24'h000020, 1'b0, 24'h000011);
    chk_tx("nakclr", 8'h1F, 24'h000020, 24'h000001);
    n_chk++; if (nak !== 1'b0 || epsn !== 24'h000021) begin n_fail++; $display("FAIL nak_clear: nak %b epsn %h required 0 000021", nak, epsn); end
  endtask

  task automatic test_filter;
    send(8'h0A, 24'h000021, 1'b1, 24'h000012);
    chk_none("badqp", 24'h000021, 24'h000001);
    send(8'h04, 24'h000021, 1'b1, 24'h000011);
    chk_none("badop", 24'h000021, 24'h000001);
    send(8'h0C, 24'h000021, 1'b1, 24'h000011);
    chk_none("badop_hi", 24'h000021, 24'h000001);
    send(8'h07, 24'h000021, 1'b1, 24'h000011);
    chk_tx("ackreq", 8'h1F, 24'h000021, 24'h000001);
  endtask

  task automatic test_wrap;
    qp_init(24'hFFFFFF);
    send(8'h0A, 24'hFFFFFF, 1'b0, 24'h000011);
    chk_tx("wrap", 8'h1F, 24'hFFFFFF, 24'h000001);
    n_chk++; if (epsn !== 24'h000000) begin n_fail++; $display("FAIL wrap_epsn: got %h required 000000", epsn); end
  endtask

  task automatic test_dup;
    qp_init(24'h000030);
    send(8'h0A, 24'h00002E, 1'b0, 24'h000011);
`ifdef ROCE_DUP_ACK_EN
    chk_tx("dup", 8'h1F, 24'h00002F, 24'h0);
    n_chk++; if (epsn !== 24'h000030 || msn !== 24'h0) begin n_fail++; $display("FAIL dup_state: epsn %h msn %h required 000030 000000", epsn, msn); end
`else
    chk_none("dup", 24'h000030, 24'h0);
`endif
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    tx_ready = 1'b0;
    send(8'h0A, 24'h000030, 1'b0, 24'h000011);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 3) begin
        n_chk++; if (tx_valid !== 1'b1 || aeth_valid !== 1'b1 || tx_psn !== 24'h000030 || tx_msn !== 24'h000001 || tx_syn !== 8'h1F)
          begin n_fail++; $display("FAIL bp_hold%0d: vld %b psn %h msn %h syn %h required 1 000030 000001 1f", i, tx_valid, tx_psn, tx_msn, tx_syn); end
        n_chk++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL bp_rxrdy%0d: got %b required 0", i, rx_ready); end
        if (i == 2) begin init_epsn = 24'h000040; rst_qp = 1'b1; end
      end else begin
        rst_qp = 1'b0;
        n_chk++; if (tx_valid !== 1'b0 || aeth_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drop%0d: vld %b%b required 00", i, tx_valid, aeth_valid); end
        n_chk++; if (rx_ready !== 1'b1 || msn !== 24'h0 || epsn !== 24'h000040) begin n_fail++; $display("FAIL bp_reinit%0d: rdy %b msn %h epsn %h required 1 000000 000040", i, rx_ready, msn, epsn); end
      end
    end
    tx_ready = 1'b1;
  endtask

  task automatic test_back_to_back;
    int c0;
    c0 = tx_cnt;
    send(8'h0A, 24'h000040, 1'b0, 24'h000011);
    chk_tx("b2b0", 8'h1F, 24'h000040, 24'h000001);
    send(8'h0B, 24'h000041, 1'b0, 24'h000011);
    chk_tx("b2b1", 8'h1F, 24'h000041, 24'h000002);
    @(negedge clk);
    n_chk++; if (tx_cnt - c0 !== 2 || epsn !== 24'h000042) begin n_fail++; $display("FAIL b2b_end: cnt %0d epsn %h required 2 000042", tx_cnt - c0, epsn); end
  endtask

  initial begin
    test_reset;
    test_write_ack;
    test_nak;
    test_filter;
    test_wrap;
    test_dup;
    test_backpressure;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
